alu_ctrl_pipe: RTL and testbench
================================

# alu_ctrl_pipe

Registered, handshaked ALU control stage for the Antares-R2 decode path. It decodes the 6-bit opcode and funct into a parametrised-width ALU operation code and holds it in one pipeline register with valid/ready flow control. It also recognises the multiply/divide group, issues a start pulse to the multi-cycle MD unit, and back-pressures decode while that unit is busy. Unrecognised encodings are flagged as illegal.

## Interface
- `ALUOP_W`, 4: width of `alu_op`; the `ALU_*` codes from ALUop.vh are zero-extended to this width.
- `MD_LAT`, 32: MD unit busy time in cycles; legal range 1..255.
- `CNT_W`, 8: width of the illegal-instruction counter.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: drops the held output entry.
- `in_valid` in 1: opcode/funct valid.
- `in_ready` out 1: stage accepts this cycle.
- `opcode` in 6: instruction[31:26].
- `funct` in 6: instruction[5:0].
- `out_valid` out 1: registered decode valid.
- `out_ready` in 1: downstream consumes.
- `alu_op` out ALUOP_W: decoded ALU operation.
- `is_md` out 1: entry is MULT/MULTU/DIV/DIVU.
- `md_op` out 2: funct[1:0] of the MD op.
- `md_start` out 1: one-cycle pulse to the MD unit.
- `md_busy` out 1: MD unit occupied.
- `illegal` out 1: entry is an unrecognised encoding.
- `illegal_cnt` out CNT_W: saturating illegal count (see Configuration).

## Operation
- Decode table:
  - RTYPE (6'h00) with funct:
    - SLL/SLLV (00/04) → ALU_SLL.
    - SRL/SRLV (02/06) → ALU_SRL.
    - SRA/SRAV (03/07) → ALU_SRA.
    - ADDU 21 → ADDU; SUBU 23 → SUBU; AND 24 → AND; OR 25 → OR; XOR 26 → XOR; NOR 27 → NOR; SLT 2A → SLT; SLTU 2B → SLTU.
    - MULT/MULTU/DIV/DIVU (18–1B) → `alu_op`=ALU_XXX, `is_md`=1.
  - LB/LH/LW/LBU/LHU/SB/SH/SW (20,21,23,24,25,28,29,2B) → ADDU.
  - ADDIU 09 → ADDU; SLTI 0A → SLT; SLTIU 0B → SLTU; ANDI 0C → AND; ORI 0D → OR; XORI 0E → XOR; LUI 0F → LUI.
  - Any other opcode, or any other RTYPE funct → ALU_XXX with `illegal`=1.
- Every case is fully assigned; there are no latches and no duplicate case items.
- `in_ready` = `state==IDLE` && !`flush` && (!`out_valid` || `out_ready`).
- Accept = `in_valid` && `in_ready`. On accept the decode is registered and `out_valid` is set.
- If there is no accept and `out_ready` is high, `out_valid` clears.
- FSM states:
  - IDLE: on accept of an MD op, assert `md_start` for one cycle, load `md_cnt`=MD_LAT-1, and go to BUSY.
  - BUSY: `md_busy`=1 and `in_ready`=0. `md_cnt` decrements each cycle. At `md_cnt`==0 the FSM returns to IDLE on the next edge.
- `flush`: clears `out_valid` on the next edge and blocks accept that cycle. It does not abort BUSY (the MD unit has already started), and it does not clear `illegal_cnt`.
- An illegal entry still flows downstream with `out_valid`; trapping is the consumer's job.

## Timing
- Reset values: `out_valid`=0, `alu_op`=0, `is_md`=0, `md_op`=0, `md_start`=0, `md_busy`=0, `illegal`=0, `illegal_cnt`=0, state=IDLE.
- Asserting `rst_n` low mid-BUSY returns everything to reset values immediately (asynchronously).
- Latency: accept at edge N gives `out_valid` and the decode visible after edge N (one cycle).
- `md_start` is high exactly for the cycle after the accepting edge.
- `md_busy` is high for exactly MD_LAT cycles, beginning that same cycle.
- `in_ready` returns high the first cycle after `md_busy` falls. With MD_LAT=1, BUSY lasts one cycle.
- Back-to-back non-MD ops with `out_ready`=1 sustain one accept per cycle.
- While `out_valid` && !`out_ready`, all outputs hold stable.
- `flush` and `out_ready` in the same cycle: the entry is dropped; the consumer must ignore the transfer.

## Configuration
- `ILLEGAL_CNT_EN` defined:
  - `illegal_cnt` increments by 1 on each accepted illegal instruction.
  - It saturates at 2^CNT_W-1 and is cleared only by reset.
- `ILLEGAL_CNT_EN` undefined:
  - The counter logic is not built; `illegal_cnt` is tied to 0.
  - `illegal` is unaffected.

## Test plan
- Decode sweep: ADDU (op 00, funct 21), then LW (op 23), then LUI (op 0F), all with `out_ready`=1 → `alu_op` = ALU_ADDU, ALU_ADDU, ALU_LUI on consecutive cycles; `in_ready` stays 1.
- MD with MD_LAT=4: MULTU (funct 19) → `md_start` for 1 cycle, `md_op`=2'b01, `md_busy` for 4 cycles, `in_ready`=0 for those 4 cycles, then back to 1.
- Back-pressure: `out_ready`=0 while SUBU is held → `in_ready`=0 and outputs stable for 3 cycles; raising `out_ready` completes the transfer and accepts the next op the same cycle.
- Flush: `flush` during a held ORI entry → `out_valid`=0 the next cycle. `flush` during BUSY → `md_busy` still runs its full MD_LAT cycles.
- Illegal: op 3F, then RTYPE funct 01, each accepted → `illegal`=1 with ALU_XXX. With `ILLEGAL_CNT_EN` and CNT_W=2, five illegal ops → `illegal_cnt`=3 (saturated).
- Reset: drop `rst_n` in the 2nd BUSY cycle → all outputs 0 immediately, state IDLE; `in_ready`=1 once `rst_n` rises.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control decode stage with valid/ready handshake and MD-unit start/busy sequencing.
// Optional saturating illegal-instruction counter is built only when ILLEGAL_CNT_EN is defined.
module alu_ctrl_pipe #(
  parameter int ALUOP_W = 4,
  parameter int MD_LAT  = 32,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_md,
  output logic [1:0]         md_op,
  output logic               md_start,
  output logic               md_busy,
  output logic               illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam logic [ALUOP_W-1:0] ALU_XXX  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(12);

  localparam logic [7:0] MD_CNT_LOAD = 8'(MD_LAT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic   [7:0]          md_cnt_reg;
  logic [ALUOP_W-1:0]    dec_op;
  logic                  dec_md;
  logic                  dec_ill;
  logic                  accept;

  always_comb begin
    dec_op  = ALU_XXX;
    dec_md  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00, 6'h04: dec_op = ALU_SLL;
          6'h02, 6'h06: dec_op = ALU_SRL;
          6'h03, 6'h07: dec_op = ALU_SRA;
          6'h21:        dec_op = ALU_ADDU;
          6'h23:        dec_op = ALU_SUBU;
          6'h24:        dec_op = ALU_AND;
          6'h25:        dec_op = ALU_OR;
          6'h26:        dec_op = ALU_XOR;
          6'h27:        dec_op = ALU_NOR;
          6'h2A:        dec_op = ALU_SLT;
          6'h2B:        dec_op = ALU_SLTU;
          6'h18, 6'h19, 6'h1A, 6'h1B: dec_md = 1'b1;
          default:      dec_ill = 1'b1;
        endcase
      end
      // loads and stores only need the address add
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: dec_op = ALU_ADDU;
      6'h09:   dec_op = ALU_ADDU;
      6'h0A:   dec_op = ALU_SLT;
      6'h0B:   dec_op = ALU_SLTU;
      6'h0C:   dec_op = ALU_AND;
      6'h0D:   dec_op = ALU_OR;
      6'h0E:   dec_op = ALU_XOR;
      6'h0F:   dec_op = ALU_LUI;
      default: dec_ill = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && dec_md) state_next = BUSY;
      BUSY:    if (md_cnt_reg == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    md_busy  = (state_reg == BUSY);
    in_ready = (state_reg == IDLE) && !flush && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_reg <= 8'd0;
    end else if (state_reg == IDLE && accept && dec_md) begin
      md_cnt_reg <= MD_CNT_LOAD;
    end else if (state_reg == BUSY && md_cnt_reg != 8'd0) begin
      md_cnt_reg <= md_cnt_reg - 8'd1;
    end
  end

  // decode fields hold after the transfer; only out_valid is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_op    <= '0;
      is_md     <= 1'b0;
      md_op     <= 2'b00;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
    end else begin
      md_start <= accept && dec_md;
      if (accept) begin
        out_valid <= 1'b1;
        alu_op    <= dec_op;
        is_md     <= dec_md;
        md_op     <= dec_md ? funct[1:0] : 2'b00;
        illegal   <= dec_ill;
      end else if (out_ready || flush) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ILLEGAL_CNT_EN
  logic [CNT_W-1:0] ill_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_reg <= '0;
    end else if (accept && dec_ill && ill_cnt_reg != {CNT_W{1'b1}}) begin
      ill_cnt_reg <= ill_cnt_reg + CNT_W'(1);
    end
  end

  assign illegal_cnt = ill_cnt_reg;
`else
  assign illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: a driver predicts handshake/MD timing and queues expected
// decodes; an independent monitor pops and compares whenever the stage presents an entry.
module tb_alu_ctrl_pipe;
  localparam int W      = 4;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 2;

  localparam logic [3:0] A_XXX = 4'd0, A_ADDU = 4'd1, A_SUBU = 4'd2, A_AND = 4'd3,
                         A_OR = 4'd4, A_XOR = 4'd5, A_NOR = 4'd6, A_SLT = 4'd7,
                         A_SLTU = 4'd8, A_SLL = 4'd9, A_SRL = 4'd10, A_SRA = 4'd11,
                         A_LUI = 4'd12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [5:0]       opcode = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     alu_op;
  logic             is_md;
  logic [1:0]       md_op;
  logic             md_start;
  logic             md_busy;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  alu_ctrl_pipe #(.ALUOP_W(W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .is_md(is_md), .md_op(md_op), .md_start(md_start),
    .md_busy(md_busy), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic       md;
    logic [1:0] mop;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_valid = 0;
  bit   exp_start = 0;
  int   busy_left = 0;
  int   exp_cnt = 0;
  logic [5:0] op_list [0:15];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [5:0] opc, input logic [5:0] fn);
    exp_t r;
    r = '{op: A_XXX, md: 1'b0, mop: 2'b00, ill: 1'b1};
    if (opc == 6'h00) begin
      r.ill = 1'b0;
      if (fn inside {6'h00, 6'h04})      r.op = A_SLL;
      else if (fn inside {6'h02, 6'h06}) r.op = A_SRL;
      else if (fn inside {6'h03, 6'h07}) r.op = A_SRA;
      else if (fn == 6'h21) r.op = A_ADDU;
      else if (fn == 6'h23) r.op = A_SUBU;
      else if (fn == 6'h24) r.op = A_AND;
      else if (fn == 6'h25) r.op = A_OR;
      else if (fn == 6'h26) r.op = A_XOR;
      else if (fn == 6'h27) r.op = A_NOR;
      else if (fn == 6'h2A) r.op = A_SLT;
      else if (fn == 6'h2B) r.op = A_SLTU;
      else if (fn >= 6'h18 && fn <= 6'h1B) begin
        r.md  = 1'b1;
        r.mop = fn[1:0];
      end else r.ill = 1'b1;
    end else if (opc inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h09}) begin
      r = '{op: A_ADDU, md: 1'b0, mop: 2'b00, ill: 1'b0};
    end else if (opc == 6'h0A) r = '{op: A_SLT,  md: 1'b0, mop: 2'b00, ill: 1'b0};
    else if (opc == 6'h0B)     r = '{op: A_SLTU, md: 1'b0, mop: 2'b00, ill: 1'b0};
    else if (opc == 6'h0C)     r = '{op: A_AND,  md: 1'b0, mop: 2'b00, ill: 1'b0};
    else if (opc == 6'h0D)     r = '{op: A_OR,   md: 1'b0, mop: 2'b00, ill: 1'b0};
    else if (opc == 6'h0E)     r = '{op: A_XOR,  md: 1'b0, mop: 2'b00, ill: 1'b0};
    else if (opc == 6'h0F)     r = '{op: A_LUI,  md: 1'b0, mop: 2'b00, ill: 1'b0};
    return r;
  endfunction

  // One clock of stimulus: drive, check handshake/MD outputs, then advance the model at the edge
  task automatic cycle(input bit v, input logic [5:0] opc, input logic [5:0] fn,
                       input bit ordy, input bit fl);
    bit   model_ready;
    bit   acc;
    exp_t d;
    @(negedge clk);
    in_valid = v; opcode = opc; funct = fn; out_ready = ordy; flush = fl;
    #1;
    model_ready = (busy_left == 0) && !fl && (!exp_valid || ordy);
    check("in_ready", int'(in_ready), int'(model_ready));
    check("md_busy", int'(md_busy), int'(busy_left > 0));
    check("md_start", int'(md_start), int'(exp_start));
    check("out_valid", int'(out_valid), int'(exp_valid));
    check("illegal_cnt", int'(illegal_cnt), exp_cnt);
    acc = v && model_ready;
    d = ref_decode(opc, fn);
    $display("cyc t=%0t v=%0b op=%02h fn=%02h ordy=%0b fl=%0b acc=%0b", $time, v, opc, fn, ordy, fl, acc);
    @(posedge clk);
    exp_start = acc && d.md;
    if (busy_left > 0) busy_left--;
    if (acc && d.md) busy_left = MD_LAT;
    if (exp_valid && fl && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (acc) exp_valid = 1'b1;
    else if (ordy || fl) exp_valid = 1'b0;
`ifdef ILLEGAL_CNT_EN
    if (acc && d.ill && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
  endtask

  task automatic check_all_zero();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_is_md", int'(is_md), 0);
    check("rst_md_op", int'(md_op), 0);
    check("rst_md_start", int'(md_start), 0);
    check("rst_md_busy", int'(md_busy), 0);
    check("rst_illegal", int'(illegal), 0);
    check("rst_illegal_cnt", int'(illegal_cnt), 0);
  endtask

  // Monitor: compares the held entry every cycle it is presented, pops on a real transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: out_valid with no expected entry at %0t", $time);
        end else begin
          e = q[0];
          check("alu_op", int'(alu_op), int'(e.op));
          check("is_md", int'(is_md), int'(e.md));
          check("md_op", int'(md_op), int'(e.mop));
          check("illegal", int'(illegal), int'(e.ill));
          if (out_ready && !flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    op_list = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h23, 6'h2B, 6'h09,
                6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h10};
    rst_n = 1'b0;
    #12;
    check_all_zero();
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // decode sweep: ADDU, LW, LUI back to back
    cycle(1, 6'h00, 6'h21, 1, 0);
    cycle(1, 6'h23, 6'h00, 1, 0);
    cycle(1, 6'h0F, 6'h00, 1, 0);
    cycle(0, 6'h00, 6'h00, 1, 0);

    // MULTU then decode keeps offering ADDU while the MD unit is busy
    cycle(1, 6'h00, 6'h19, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 6'h00, 6'h21, 1, 0);
    cycle(0, 6'h00, 6'h00, 1, 0);

    // back-pressure on a held SUBU, then release
    cycle(1, 6'h00, 6'h23, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 6'h00, 6'h24, 0, 0);
    cycle(1, 6'h00, 6'h24, 1, 0);
    cycle(0, 6'h00, 6'h00, 1, 0);

    // flush a held ORI, then flush during BUSY
    cycle(1, 6'h0D, 6'h00, 0, 0);
    cycle(0, 6'h00, 6'h00, 0, 1);
    cycle(0, 6'h00, 6'h00, 1, 0);
    cycle(1, 6'h00, 6'h1A, 1, 0);
    cycle(0, 6'h00, 6'h00, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 6'h00, 6'h00, 1, 0);

    // five illegal encodings
    cycle(1, 6'h3F, 6'h00, 1, 0);
    cycle(1, 6'h00, 6'h01, 1, 0);
    cycle(1, 6'h10, 6'h21, 1, 0);
    cycle(1, 6'h00, 6'h3F, 1, 0);
    cycle(1, 6'h3F, 6'h3F, 1, 0);
    cycle(0, 6'h00, 6'h00, 1, 0);

    // asynchronous reset in the second BUSY cycle
    cycle(1, 6'h00, 6'h18, 1, 0);
    cycle(0, 6'h00, 6'h00, 1, 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    q.delete();
    exp_valid = 0; exp_start = 0; busy_left = 0; exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 6'h00, 6'h00, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] opc;
      logic [5:0] fn;
      opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 15)];
      fn  = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(6'h18, 6'h1B)) : 6'($urandom);
      cycle($urandom_range(0, 9) < 8, opc, fn, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    cycle(0, 6'h00, 6'h00, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
